axis_stemlab_sdr_dac: RTL and testbench

AXIS_STEMLAB_SDR_DAC -- requirements
Module: axis_stemlab_sdr_dac

---
 rtl/axis_stemlab_sdr_dac.sv | 188 ++++++++++++++++++
 tb/tb_axis_stemlab_sdr_dac.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stemlab_sdr_dac.sv
// ---------------------------------------------------------------------------
// axis_stemlab_sdr_dac
//
// Takes paired AXI-Stream samples (channel A and channel B) and drives the
// STEMlab/SDR dual DAC bus. The DAC bus is interleaved: A and B share one
// 14-bit data bus, and dac_sel selects the channel. So one A/B pair is
// consumed every two aclk cycles.
//
// After reset the DAC is held in reset for RST_CYCLES cycles. The block then
// waits for the first complete pair and streams from then on. If a pair is
// missing when it is due, that is an underrun. On an underrun the block
// either repeats the last pair or substitutes midscale, as set by
// UNDERRUN_ZERO.
//
// Parameters
//   RST_CYCLES     dac_rst hold length after reset release (1..255)
//   UNDERRUN_ZERO  0: repeat last pair on underrun, 1: output zero samples
//
// Ports
//   aclk             system clock, rising edge
//   areset           synchronous active-high reset
//   s_axis_a_tdata   channel A sample, two's complement
//   s_axis_a_tvalid  channel A valid
//   s_axis_a_tready  channel A ready (always equal to s_axis_b_tready)
//   s_axis_b_tdata   channel B sample, two's complement
//   s_axis_b_tvalid  channel B valid
//   s_axis_b_tready  channel B ready
//   dac_dat          interleaved DAC word, board format
//   dac_sel          1 = dac_dat carries A, 0 = B
//   dac_wrt          write strobe, high while dac_dat is valid
//   dac_rst          DAC reset, active-high
//   underrun         one-cycle pulse per missed pair
//   underrun_cnt     saturating count of missed pairs
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST_HOLD | DAC held in reset, counting RST_CYCLES after release
// PRIME    | DAC idle at midscale, waiting for the first A/B pair
// RUN      | interleaving A (PH_A) and B (PH_B); pair slot on PH_B
// ---------------------------------------------------------------------------
module axis_stemlab_sdr_dac #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter bit          UNDERRUN_ZERO = 1'b0
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [15:0] s_axis_a_tdata,
   input  logic        s_axis_a_tvalid,
   output logic        s_axis_a_tready,
   input  logic [15:0] s_axis_b_tdata,
   input  logic        s_axis_b_tvalid,
   output logic        s_axis_b_tready,
   output logic [13:0] dac_dat,
   output logic        dac_sel,
   output logic        dac_wrt,
   output logic        dac_rst,
   output logic        underrun,
   output logic [15:0] underrun_cnt
);

   typedef enum logic [1:0] {
      RST_HOLD = 2'd0,
      PRIME    = 2'd1,
      RUN      = 2'd2
   } state_t;

   typedef enum logic {
      PH_A = 1'b0,
      PH_B = 1'b1
   } phase_t;

   localparam logic [13:0] DAC_MID  = 14'h1FFF;
   localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
   localparam logic [15:0] CNT_MAX  = 16'hFFFF;

   state_t      state;
   phase_t      phase;
   logic [7:0]  rst_cnt;

   // The two LSBs are dropped when a sample is taken. So the hold registers
   // keep only the bits that reach the DAC.
   logic [13:0] hold_a;
   logic [13:0] hold_b;

   logic        both_valid;
   logic        pair_slot;
   logic        pair_xfer;
   logic        pair_miss;
   logic [15:0] underrun_cnt_nxt;

   logic        unused_lsbs;
   assign unused_lsbs = ^{s_axis_a_tdata[1:0], s_axis_b_tdata[1:0]};

   // Board format: the sign bit passes through and the magnitude bits are
   // inverted. So 0 maps to midscale 14'h1FFF.
   function automatic logic [13:0] conv(input logic [13:0] h);
      return {h[13], ~h[12:0]};
   endfunction

   assign both_valid = s_axis_a_tvalid & s_axis_b_tvalid;
   assign pair_slot  = (state == PRIME) || ((state == RUN) && (phase == PH_B));
   assign pair_xfer  = both_valid & pair_slot;
   assign pair_miss  = (state == RUN) && (phase == PH_B) && !both_valid;

   // The readies depend on both valids. So a lone sample is never consumed
   // and the two channels stay aligned.
   assign s_axis_a_tready = pair_xfer;
   assign s_axis_b_tready = pair_xfer;

   always_comb begin
      underrun_cnt_nxt = underrun_cnt;
      if (pair_miss && (underrun_cnt != CNT_MAX)) begin
         underrun_cnt_nxt = underrun_cnt + 16'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state        <= RST_HOLD;
         phase        <= PH_A;
         rst_cnt      <= 8'd0;
         hold_a       <= 14'd0;
         hold_b       <= 14'd0;
         underrun     <= 1'b0;
         underrun_cnt <= 16'd0;
         dac_rst      <= 1'b1;
         dac_wrt      <= 1'b0;
         dac_dat      <= DAC_MID;
         dac_sel      <= 1'b0;
      end else begin
         underrun     <= pair_miss;
         underrun_cnt <= underrun_cnt_nxt;

         case (state)
            RST_HOLD: begin
               dac_dat <= DAC_MID;
               dac_sel <= 1'b0;
               if (rst_cnt == RST_LAST) begin
                  state   <= PRIME;
                  dac_rst <= 1'b0;
                  dac_wrt <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + 8'd1;
               end
            end

            PRIME: begin
               dac_dat <= DAC_MID;
               dac_sel <= 1'b0;
               dac_wrt <= 1'b1;
               if (pair_xfer) begin
                  hold_a <= s_axis_a_tdata[15:2];
                  hold_b <= s_axis_b_tdata[15:2];
                  state  <= RUN;
                  phase  <= PH_A;
               end
            end

            RUN: begin
               dac_wrt <= 1'b1;
               if (phase == PH_A) begin
                  dac_dat <= conv(hold_a);
                  dac_sel <= 1'b1;
                  phase   <= PH_B;
               end else begin
                  // B is still taken from the old hold_b. The new pair
                  // lands at the next edge, one cycle ahead of its A slot.
                  dac_dat <= conv(hold_b);
                  dac_sel <= 1'b0;
                  phase   <= PH_A;
                  if (pair_xfer) begin
                     hold_a <= s_axis_a_tdata[15:2];
                     hold_b <= s_axis_b_tdata[15:2];
                  end else if (UNDERRUN_ZERO) begin
                     hold_a <= 14'd0;
                     hold_b <= 14'd0;
                  end
               end
            end

            default: begin
               state <= RST_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_stemlab_sdr_dac.sv
module tb_axis_stemlab_sdr_dac;

   localparam int RST_CYCLES = 4;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [15:0] a_dat = 16'd0;
   logic [15:0] b_dat = 16'd0;
   logic        a_vld = 1'b0;
   logic        b_vld = 1'b0;

   logic        a_rdy0, b_rdy0, sel0, wrt0, rst0, ur0;
   logic [13:0] dat0;
   logic [15:0] urc0;
   logic        a_rdy1, b_rdy1, sel1, wrt1, rst1, ur1;
   logic [13:0] dat1;
   logic [15:0] urc1;

   axis_stemlab_sdr_dac #(.RST_CYCLES(RST_CYCLES), .UNDERRUN_ZERO(1'b0)) dut0 (
      .aclk(aclk), .areset(areset),
      .s_axis_a_tdata(a_dat), .s_axis_a_tvalid(a_vld), .s_axis_a_tready(a_rdy0),
      .s_axis_b_tdata(b_dat), .s_axis_b_tvalid(b_vld), .s_axis_b_tready(b_rdy0),
      .dac_dat(dat0), .dac_sel(sel0), .dac_wrt(wrt0), .dac_rst(rst0),
      .underrun(ur0), .underrun_cnt(urc0)
   );

   axis_stemlab_sdr_dac #(.RST_CYCLES(RST_CYCLES), .UNDERRUN_ZERO(1'b1)) dut1 (
      .aclk(aclk), .areset(areset),
      .s_axis_a_tdata(a_dat), .s_axis_a_tvalid(a_vld), .s_axis_a_tready(a_rdy1),
      .s_axis_b_tdata(b_dat), .s_axis_b_tvalid(b_vld), .s_axis_b_tready(b_rdy1),
      .dac_dat(dat1), .dac_sel(sel1), .dac_wrt(wrt1), .dac_rst(rst1),
      .underrun(ur1), .underrun_cnt(urc1)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int          cyc;
      logic [13:0] dat;
      logic        sel;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          urq[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          chk_en = 1'b0;
   logic [15:0] exp_cnt = 16'd0;
   logic [15:0] last_a0 = 16'd0, last_b0 = 16'd0;
   logic [15:0] last_a1 = 16'd0, last_b1 = 16'd0;

   function automatic logic [13:0] conv(input logic [15:0] d);
      return {d[15], ~d[14:2]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at cyc %0d", tag, got, exp, cyc);
      end
   endtask

   always @(posedge aclk) cyc <= cyc + 1;

   // Scoreboard side: pop expected DAC words and underrun pulses as they fall due.
   always @(negedge aclk) begin
      exp_t e;
      bit   exp_ur;
      #2;
      if (chk_en) begin
         if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            e = q0.pop_front();
            check("sb0_cyc", cyc, e.cyc);
            check("sb0_dat", 32'(dat0), 32'(e.dat));
            check("sb0_sel", 32'(sel0), 32'(e.sel));
            check("sb0_wrt", 32'(wrt0), 1);
         end
         if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            check("sb1_cyc", cyc, e.cyc);
            check("sb1_dat", 32'(dat1), 32'(e.dat));
            check("sb1_sel", 32'(sel1), 32'(e.sel));
            check("sb1_wrt", 32'(wrt1), 1);
         end
         exp_ur = (urq.size() > 0) && (urq[0] == cyc);
         if (exp_ur) begin
            void'(urq.pop_front());
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end
         check("underrun0", 32'(ur0), 32'(exp_ur));
         check("underrun1", 32'(ur1), 32'(exp_ur));
         check("ur_cnt0", 32'(urc0), 32'(exp_cnt));
         check("ur_cnt1", 32'(urc1), 32'(exp_cnt));
      end
   end

   // Called at the negedge of a RUN PH_A cycle: readies must stay low even with both valid.
   task automatic ph_a_fill();
      a_vld = 1'b1;
      b_vld = 1'b1;
      a_dat = 16'($urandom);
      b_dat = 16'($urandom);
      #1;
      check("rdy_a_pha", 32'(a_rdy0), 0);
      check("rdy_b_pha", 32'(b_rdy1), 0);
      @(negedge aclk);
   endtask

   // Called at the negedge of a pair slot (PRIME or RUN PH_B).
   task automatic ph_b_slot(input logic av, input logic bv, input logic [15:0] a, input logic [15:0] b);
      int n;
      a_vld = av;
      b_vld = bv;
      a_dat = a;
      b_dat = b;
      #1;
      n = cyc;
      check("rdy_a0_slot", 32'(a_rdy0), 32'(av & bv));
      check("rdy_b0_slot", 32'(b_rdy0), 32'(av & bv));
      check("rdy_a1_slot", 32'(a_rdy1), 32'(av & bv));
      check("rdy_b1_slot", 32'(b_rdy1), 32'(av & bv));
      if (av && bv) begin
         last_a0 = a; last_b0 = b;
         last_a1 = a; last_b1 = b;
      end else begin
         urq.push_back(n + 1);
         last_a1 = 16'd0; last_b1 = 16'd0;
      end
      q0.push_back(exp_t'{cyc: n + 2, dat: conv(last_a0), sel: 1'b1});
      q0.push_back(exp_t'{cyc: n + 3, dat: conv(last_b0), sel: 1'b0});
      q1.push_back(exp_t'{cyc: n + 2, dat: conv(last_a1), sel: 1'b1});
      q1.push_back(exp_t'{cyc: n + 3, dat: conv(last_b1), sel: 1'b0});
      @(negedge aclk);
   endtask

   // Count dac_rst high cycles from the release point; leaves us at a PRIME negedge.
   task automatic release_and_hold();
      int hi;
      areset = 1'b0;
      #1;
      hi = rst0 ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge aclk);
         #1;
         if (!rst0) break;
         hi++;
         check("hold_rdy", 32'(a_rdy0), 0);
         check("hold_dat", 32'(dat0), 32'h1FFF);
      end
      check("hold_len", hi, RST_CYCLES);
      check("prime_rst", 32'(rst0), 0);
      check("prime_wrt", 32'(wrt0), 1);
      check("prime_dat", 32'(dat0), 32'h1FFF);
      check("prime_sel", 32'(sel0), 0);
      a_vld = 1'b0;
      b_vld = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      areset = 1'b1;
      a_vld = 1'b1;
      b_vld = 1'b1;
      a_dat = 16'h1234;
      b_dat = 16'h4321;
      repeat (3) @(negedge aclk);
      #1;
      check("rst_dac_rst", 32'(rst0), 1);
      check("rst_wrt", 32'(wrt0), 0);
      check("rst_dat", 32'(dat0), 32'h1FFF);
      check("rst_sel", 32'(sel0), 0);
      check("rst_rdy_a", 32'(a_rdy0), 0);
      check("rst_rdy_b", 32'(b_rdy0), 0);
      check("rst_ur", 32'(ur0), 0);
      check("rst_cnt", 32'(urc0), 0);
      check("rst1_dac_rst", 32'(rst1), 1);
      check("rst1_dat", 32'(dat1), 32'h1FFF);

      chk_en = 1'b1;
      release_and_hold();

      // PRIME with a lone valid: nothing taken, no underrun counted.
      repeat (3) begin
         @(negedge aclk);
         a_vld = 1'b1;
         b_vld = 1'b0;
         #1;
         check("prime_lone_rdy", 32'(a_rdy0), 0);
      end
      @(negedge aclk);

      // First pair at full-scale extremes.
      ph_b_slot(1'b1, 1'b1, 16'h7FFF, 16'h8000);
      #1;
      check("run_first_dat", 32'(dat0), 32'h1FFF);
      check("run_first_sel", 32'(sel0), 0);

      // Continuous stream A=n, B=-n.
      for (int i = 1; i <= 8; i++) begin
         ph_a_fill();
         ph_b_slot(1'b1, 1'b1, 16'(i), 16'(-i));
      end

      // Underruns: lone A, then lone B, then recovery.
      ph_a_fill();
      ph_b_slot(1'b1, 1'b0, 16'h1111, 16'h2222);
      ph_a_fill();
      ph_b_slot(1'b0, 1'b1, 16'h3333, 16'h4444);
      ph_a_fill();
      ph_b_slot(1'b1, 1'b1, 16'h0000, 16'hFFFF);

      repeat (4) begin
         ph_a_fill();
         ph_b_slot(1'b1, 1'b1, 16'($urandom), 16'($urandom));
      end

      // Saturation: preload the count just below the top, then miss three pairs.
      force dut0.underrun_cnt = 16'hFFFE;
      force dut1.underrun_cnt = 16'hFFFE;
      exp_cnt = 16'hFFFE;
      ph_a_fill();
      release dut0.underrun_cnt;
      release dut1.underrun_cnt;
      ph_b_slot(1'b1, 1'b0, 16'h5555, 16'h6666);
      ph_a_fill();
      ph_b_slot(1'b0, 1'b0, 16'h5555, 16'h6666);
      ph_a_fill();
      ph_b_slot(1'b0, 1'b1, 16'h5555, 16'h6666);
      ph_a_fill();
      ph_b_slot(1'b1, 1'b1, 16'h0ABC, 16'hF123);
      check("sat_cnt0", 32'(urc0), 32'hFFFF);
      check("sat_cnt1", 32'(urc1), 32'hFFFF);

      // Reset mid-RUN at a PH_B slot with both valid.
      ph_a_fill();
      a_vld = 1'b1;
      b_vld = 1'b1;
      areset = 1'b1;
      #3;
      chk_en = 1'b0;
      q0.delete();
      q1.delete();
      urq.delete();
      @(negedge aclk);
      #1;
      check("mid_rst_dac_rst", 32'(rst0), 1);
      check("mid_rst_dat", 32'(dat0), 32'h1FFF);
      check("mid_rst_sel", 32'(sel0), 0);
      check("mid_rst_wrt", 32'(wrt0), 0);
      check("mid_rst_cnt", 32'(urc0), 0);
      check("mid_rst_ur", 32'(ur0), 0);
      check("mid_rst_rdy", 32'(a_rdy0), 0);
      check("mid_rst1_cnt", 32'(urc1), 0);

      // Come back up and stream one more pair to see the path recover.
      exp_cnt = 16'd0;
      last_a0 = 16'd0; last_b0 = 16'd0;
      last_a1 = 16'd0; last_b1 = 16'd0;
      @(negedge aclk);
      chk_en = 1'b1;
      release_and_hold();
      @(negedge aclk);
      ph_b_slot(1'b1, 1'b1, 16'h0000, 16'hFFFF);
      ph_a_fill();
      ph_b_slot(1'b1, 1'b1, 16'h4000, 16'hC000);
      ph_a_fill();
      @(negedge aclk);
      #3;
      check("drain_q0", q0.size(), 0);
      check("drain_q1", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
